// File: rtl/vme_pkg.sv
// Shared definitions for the EA4163 VME A16 slave: address modifiers,
// board base address and the bus-cycle sequencer state encoding.
package vme_pkg;

  // A16 address modifiers accepted by the board window
  localparam logic [5:0] AM_A16_NP  = 6'h29;  // non-privileged
  localparam logic [5:0] AM_A16_SUP = 6'h2D;  // supervisory

  // Board window base (A[15:6] significant, 32 word registers)
  localparam logic [15:0] EA4163_BASE = 16'h7C80;

  // Bus-cycle sequencer states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_ACCESS   = 3'd2,
    S_WAIT     = 3'd3,
    S_DTACK    = 3'd4,
    S_RELEASE  = 3'd5,
    S_WAIT_REL = 3'd6
  } vme_state_t;

  // True for the A16 modifiers this board answers to
  function automatic logic am_is_a16(input logic [5:0] am);
    return (am == AM_A16_NP) || (am == AM_A16_SUP);
  endfunction

endpackage

// File: rtl/vme_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous VME strobes.
// Both stages reset to RST_VAL so the strobes read as "idle" out of reset.
module vme_sync #(
  parameter int unsigned         W       = 1,
  parameter logic [W-1:0]        RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vme_slave_ctrl.sv
// VME A16 slave-cycle sequencer for the EA4163 board.
// Synchronises the VME strobes, decodes address/AM against the board
// window, issues single-cycle register strobes, steers the data-bus
// direction and generates DTACK with active negation.
//
// Bus handshake: a cycle starts when synced AS and at least one synced DS
// are low. The slave answers by driving DTACK low (DTACK_EN=1, DTACK_D=0)
// and holds it until both synced DS are high again; it then drives DTACK
// high for one cycle (active negation) before releasing the line. DS is
// the only release condition; AS is only used to re-arm for the next cycle.
module vme_slave_ctrl
  import vme_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = EA4163_BASE,
  parameter int unsigned DTACK_DELAY = 2,    // 0..15
  parameter int unsigned TIMEOUT     = 255   // 1..255
) (
  input  logic        I_CLK_32M,
  input  logic        I_VME_SYSRESET,
  input  logic        I_VME_AS,
  input  logic        I_VME_DS0,
  input  logic        I_VME_DS1,
  input  logic        I_VME_WR,
  input  logic        I_VME_LWORD,
  input  logic [15:1] I_VME_A,
  input  logic [5:0]  I_VME_AM,
  input  logic [15:0] I_VME_D,
  input  logic [15:0] I_REG_RDATA,
  output logic [4:0]  O_REG_ADDR,
  output logic [1:0]  O_REG_BE,
  output logic        O_REG_WR,
  output logic        O_REG_RD,
  output logic [15:0] O_WDATA,
  output logic [15:0] O_RDATA,
  output logic        O_D_OE,
  output logic        O_VME_DTACK_D,
  output logic        O_VME_DTACK_EN,
  output logic        O_BUSY,
  output logic        O_TIMEOUT,
  output vme_state_t  O_DBG_STATE
);

  localparam logic [3:0] DLY     = DTACK_DELAY[3:0];
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  // Synchronised strobes, ordered {WR, DS1, DS0, AS}; all idle high
  logic [3:0] sync_q;
  logic       as_s;
  logic       ds0_s;
  logic       ds1_s;
  logic       wr_s;

  vme_sync #(
    .W       (4),
    .RST_VAL (4'b1111)
  ) u_sync (
    .clk (I_CLK_32M),
    .rst (I_VME_SYSRESET),
    .d   ({I_VME_WR, I_VME_DS1, I_VME_DS0, I_VME_AS}),
    .q   (sync_q)
  );

  assign as_s  = sync_q[0];
  assign ds0_s = sync_q[1];
  assign ds1_s = sync_q[2];
  assign wr_s  = sync_q[3];

  // Address/AM/LWORD are read straight from the pins in DECODE: synced AS
  // is low there, so the master guarantees they are stable.
  logic addr_hit;
  logic ds_any_s;
  assign addr_hit = am_is_a16(I_VME_AM)
                  && (I_VME_A[15:6] == BASE_ADDR[15:6])
                  && I_VME_LWORD;
  assign ds_any_s = ~ds0_s | ~ds1_s;

  // The synchronizer resets to "idle" values, which would make an AS that
  // is still low across reset look high for two cycles. Wait for the
  // synchronizer to fill with real pin samples before leaving WAIT_REL.
  logic [1:0] prime_cnt;
  logic       sync_ok;
  assign sync_ok = prime_cnt[1];

  // Count synchronizer fill cycles after reset, then hold
  always_ff @(posedge I_CLK_32M or posedge I_VME_SYSRESET) begin
    if (I_VME_SYSRESET) begin
      prime_cnt <= 2'd0;
    end else if (!sync_ok) begin
      prime_cnt <= prime_cnt + 2'd1;
    end
  end

  vme_state_t state;
  logic [3:0] wait_cnt;
  logic [7:0] to_cnt;
  logic       is_write;

  assign O_BUSY      = (state != S_IDLE);
  assign O_DBG_STATE = state;

  // Bus-cycle sequencer with registered outputs set on each transition
  always_ff @(posedge I_CLK_32M or posedge I_VME_SYSRESET) begin
    if (I_VME_SYSRESET) begin
      state          <= S_WAIT_REL;
      wait_cnt       <= 4'd0;
      to_cnt         <= 8'd0;
      is_write       <= 1'b0;
      O_REG_ADDR     <= 5'd0;
      O_REG_BE       <= 2'd0;
      O_REG_WR       <= 1'b0;
      O_REG_RD       <= 1'b0;
      O_WDATA        <= 16'd0;
      O_RDATA        <= 16'd0;
      O_D_OE         <= 1'b0;
      O_VME_DTACK_D  <= 1'b1;
      O_VME_DTACK_EN <= 1'b0;
      O_TIMEOUT      <= 1'b0;
    end else begin
      // Strobes and the timeout flag are single-cycle pulses
      O_REG_WR  <= 1'b0;
      O_REG_RD  <= 1'b0;
      O_TIMEOUT <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!as_s && ds_any_s) begin
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          // A DS that went back high before decode is treated as a glitch
          if (addr_hit && ds_any_s) begin
            O_REG_ADDR <= I_VME_A[5:1];
            O_REG_BE   <= {~ds1_s, ~ds0_s};
            O_WDATA    <= I_VME_D;
            is_write   <= ~wr_s;
            O_REG_WR   <= ~wr_s;
            O_REG_RD   <= wr_s;
            state      <= S_ACCESS;
          end else begin
            state <= S_WAIT_REL;
          end
        end

        S_ACCESS: begin
          // The register block has O_REG_ADDR stable this cycle
          if (!is_write) begin
            O_RDATA <= I_REG_RDATA;
          end
          O_D_OE   <= ~is_write;
          wait_cnt <= 4'd1;
          to_cnt   <= 8'd0;
          if (DLY == 4'd0) begin
            O_VME_DTACK_EN <= 1'b1;
            O_VME_DTACK_D  <= 1'b0;
            state          <= S_DTACK;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (wait_cnt >= DLY) begin
            O_VME_DTACK_EN <= 1'b1;
            O_VME_DTACK_D  <= 1'b0;
            state          <= S_DTACK;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        S_DTACK: begin
          if (ds0_s && ds1_s) begin
            // Active negation: drive DTACK high for one cycle
            O_VME_DTACK_D <= 1'b1;
            state         <= S_RELEASE;
          end else if (to_cnt >= TO_LAST) begin
            // Master never released DS: let go of the bus
            O_TIMEOUT      <= 1'b1;
            O_VME_DTACK_EN <= 1'b0;
            O_VME_DTACK_D  <= 1'b1;
            O_D_OE         <= 1'b0;
            state          <= S_WAIT_REL;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end

        S_RELEASE: begin
          O_VME_DTACK_EN <= 1'b0;
          O_D_OE         <= 1'b0;
          state          <= S_WAIT_REL;
        end

        S_WAIT_REL: begin
          if (as_s && sync_ok) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_WAIT_REL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vme_slave_ctrl.sv
// Directed bench for vme_slave_ctrl: read/write/byte/no-match cycles,
// DTACK release timing, timeout and reset during an active cycle.
`timescale 1ns/1ps
module tb_vme_slave_ctrl;
  import vme_pkg::*;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #15.625 sysclk = ~sysclk;

  // ---------------- DUT signals ----------------
  logic        as_n    = 1'b1;
  logic        ds0_n   = 1'b1;
  logic        ds1_n   = 1'b1;
  logic        wr_n    = 1'b1;
  logic        lword_n = 1'b1;
  logic [15:1] a       = '0;
  logic [5:0]  am      = '0;
  logic [15:0] d       = '0;
  logic [15:0] reg_rdata;
  logic [4:0]  reg_addr;
  logic [1:0]  reg_be;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        d_oe;
  logic        dtack_d;
  logic        dtack_en;
  logic        busy;
  logic        timeout;
  vme_state_t  dbg_state;

  // Register file model: readback is a fixed function of the word index
  assign reg_rdata = {reg_addr, 11'h000} ^ 16'h3800;

  vme_slave_ctrl dut (
    .I_CLK_32M      (sysclk),
    .I_VME_SYSRESET (rst),
    .I_VME_AS       (as_n),
    .I_VME_DS0      (ds0_n),
    .I_VME_DS1      (ds1_n),
    .I_VME_WR       (wr_n),
    .I_VME_LWORD    (lword_n),
    .I_VME_A        (a),
    .I_VME_AM       (am),
    .I_VME_D        (d),
    .I_REG_RDATA    (reg_rdata),
    .O_REG_ADDR     (reg_addr),
    .O_REG_BE       (reg_be),
    .O_REG_WR       (reg_wr),
    .O_REG_RD       (reg_rd),
    .O_WDATA        (wdata),
    .O_RDATA        (rdata),
    .O_D_OE         (d_oe),
    .O_VME_DTACK_D  (dtack_d),
    .O_VME_DTACK_EN (dtack_en),
    .O_BUSY         (busy),
    .O_TIMEOUT      (timeout),
    .O_DBG_STATE    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Per-cycle statistics collected by run_cycle
  int n_rd, n_wr, n_oe, n_to, n_en, first_dtack, d_rise, en_drop;
  logic cyc_done;

  // One VME bus cycle: strobes fall together, DS released 'hold' cycles
  // after DTACK (or at 40+hold if DTACK never comes), AS 2 cycles later.
  task automatic run_cycle(input logic [15:0] addr, input logic [5:0] am_v,
                           input logic wr_v, input logic ds1_v, input logic ds0_v,
                           input logic [15:0] d_v, input logic lw_v, input int hold);
    int rel_cyc;
    n_rd = 0; n_wr = 0; n_oe = 0; n_to = 0; n_en = 0;
    first_dtack = 0; d_rise = 0; en_drop = 0; cyc_done = 1'b0;
    rel_cyc = 0;
    a       = addr[15:1];
    am      = am_v;
    wr_n    = wr_v;
    lword_n = lw_v;
    d       = d_v;
    as_n    = 1'b0;
    ds0_n   = ds0_v;
    ds1_n   = ds1_v;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      tick();
      if (reg_rd)   n_rd++;
      if (reg_wr)   n_wr++;
      if (d_oe)     n_oe++;
      if (timeout)  n_to++;
      if (dtack_en) n_en++;
      if (first_dtack == 0 && dtack_en && !dtack_d) first_dtack = cyc;
      if (rel_cyc != 0 && d_rise == 0 && dtack_en && dtack_d) d_rise = cyc - rel_cyc;
      if (rel_cyc != 0 && en_drop == 0 && !dtack_en) en_drop = cyc - rel_cyc;
      if (rel_cyc == 0 && ((first_dtack != 0 && cyc == first_dtack + hold) || cyc == 40 + hold)) begin
        ds0_n   = 1'b1;
        ds1_n   = 1'b1;
        rel_cyc = cyc;
      end
      if (rel_cyc != 0 && cyc == rel_cyc + 2) as_n = 1'b1;
      if (rel_cyc != 0 && cyc == rel_cyc + 8) begin
        cyc_done = 1'b1;
        break;
      end
    end
    check("cycle_completed", 32'(cyc_done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values while reset is held
    repeat (3) tick();
    check("rst_reg_wr",   32'(reg_wr),   32'd0);
    check("rst_reg_rd",   32'(reg_rd),   32'd0);
    check("rst_d_oe",     32'(d_oe),     32'd0);
    check("rst_dtack_en", 32'(dtack_en), 32'd0);
    check("rst_dtack_d",  32'(dtack_d),  32'd1);
    check("rst_timeout",  32'(timeout),  32'd0);
    check("rst_rdata",    32'(rdata),    32'd0);
    check("rst_state",    32'(dbg_state), 32'(S_WAIT_REL));
    rst = 1'b0;
    repeat (6) tick();
    check("idle_after_rst", 32'(dbg_state), 32'(S_IDLE));
    check("busy_idle",      32'(busy),      32'd0);

    // A16 read at 0x7CA4, AM 0x29
    run_cycle(16'h7CA4, 6'h29, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 2);
    check("rd_addr",        32'(reg_addr), 32'h12);
    check("rd_pulses",      32'(n_rd),     32'd1);
    check("rd_no_wr",       32'(n_wr),     32'd0);
    check("rd_rdata",       32'(rdata),    32'hA800);
    check("rd_be",          32'(reg_be),   32'h3);
    check("rd_dtack_lat",   32'(first_dtack), 32'd7);
    check("rd_oe_cycles",   32'(n_oe),     32'd8);
    check("rd_en_cycles",   32'(n_en),     32'd6);
    check("rd_d_rise",      32'(d_rise),   32'd3);
    check("rd_en_drop",     32'(en_drop),  32'd4);
    check("rd_idle",        32'(dbg_state), 32'(S_IDLE));

    // A16 write at 0x7C86, AM 0x2D
    run_cycle(16'h7C86, 6'h2D, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1);
    check("wr_pulses",      32'(n_wr),     32'd1);
    check("wr_no_rd",       32'(n_rd),     32'd0);
    check("wr_wdata",       32'(wdata),    32'h1234);
    check("wr_be",          32'(reg_be),   32'h3);
    check("wr_addr",        32'(reg_addr), 32'h03);
    check("wr_no_oe",       32'(n_oe),     32'd0);
    check("wr_dtack_lat",   32'(first_dtack), 32'd7);

    // Outside window
    run_cycle(16'h7D00, 6'h29, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
    check("nm_addr_rd",     32'(n_rd),     32'd0);
    check("nm_addr_en",     32'(n_en),     32'd0);
    check("nm_addr_idle",   32'(dbg_state), 32'(S_IDLE));

    // Wrong address modifier
    run_cycle(16'h7CA4, 6'h39, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b1, 0);
    check("nm_am_wr",       32'(n_wr),     32'd0);
    check("nm_am_en",       32'(n_en),     32'd0);
    check("nm_am_idle",     32'(dbg_state), 32'(S_IDLE));

    // LWORD asserted (32-bit access) is not ours
    run_cycle(16'h7CA4, 6'h29, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0);
    check("nm_lw_rd",       32'(n_rd),     32'd0);
    check("nm_lw_en",       32'(n_en),     32'd0);

    // Byte write, DS0 only, at 0x7C80
    run_cycle(16'h7C80, 6'h29, 1'b0, 1'b1, 1'b0, 16'h00AB, 1'b1, 2);
    check("bw_be",          32'(reg_be),   32'h1);
    check("bw_pulses",      32'(n_wr),     32'd1);
    check("bw_addr",        32'(reg_addr), 32'h00);
    check("bw_wdata",       32'(wdata),    32'h00AB);
    check("bw_d_rise",      32'(d_rise),   32'd3);
    check("bw_en_drop",     32'(en_drop),  32'd4);

    // Byte read, DS1 only, at 0x7CBE
    run_cycle(16'h7CBE, 6'h2D, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 0);
    check("br_be",          32'(reg_be),   32'h2);
    check("br_addr",        32'(reg_addr), 32'h1F);
    check("br_rdata",       32'(rdata),    32'hC000);
    check("br_pulses",      32'(n_rd),     32'd1);

    // DS held 300 cycles after DTACK: timeout
    run_cycle(16'h7CA4, 6'h29, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 300);
    check("to_pulses",      32'(n_to),     32'd1);
    check("to_en_cycles",   32'(n_en),     32'd255);
    check("to_one_rd",      32'(n_rd),     32'd1);
    check("to_idle",        32'(dbg_state), 32'(S_IDLE));

    // Reset asserted while in DTACK with AS low
    begin
      int   k;
      logic seen;
      int   n_strobe;
      int   n_en_after;
      a = 15'h3E52; am = 6'h29; wr_n = 1'b1; lword_n = 1'b1;
      as_n = 1'b0; ds0_n = 1'b0; ds1_n = 1'b0;
      seen = 1'b0;
      for (k = 0; k < 20 && !seen; k++) begin
        tick();
        if (dtack_en) seen = 1'b1;
      end
      check("rs_reached_dtack", 32'(seen), 32'd1);
      #5 rst = 1'b1;
      #1;
      check("rs_dtack_en",  32'(dtack_en), 32'd0);
      check("rs_dtack_d",   32'(dtack_d),  32'd1);
      check("rs_d_oe",      32'(d_oe),     32'd0);
      check("rs_reg_addr",  32'(reg_addr), 32'd0);
      check("rs_rdata",     32'(rdata),    32'd0);
      repeat (2) tick();
      rst = 1'b0;
      n_strobe = 0; n_en_after = 0;
      repeat (20) begin
        tick();
        if (reg_rd || reg_wr) n_strobe++;
        if (dtack_en) n_en_after++;
      end
      check("rs_no_strobe", 32'(n_strobe),   32'd0);
      check("rs_no_dtack",  32'(n_en_after), 32'd0);
      check("rs_hold_state", 32'(dbg_state), 32'(S_WAIT_REL));
      ds0_n = 1'b1; ds1_n = 1'b1; as_n = 1'b1;
      repeat (6) tick();
      check("rs_idle",      32'(dbg_state), 32'(S_IDLE));
    end

    // A fresh cycle works after the reset recovery
    run_cycle(16'h7CA4, 6'h29, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1);
    check("post_rs_rd",     32'(n_rd),     32'd1);
    check("post_rs_rdata",  32'(rdata),    32'hA800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vme_slave_ctrl.md
# vme_slave_ctrl

VME A16 slave-cycle sequencer for the EA4163 board. It synchronises the asynchronous VME strobes to the 32 MHz system clock and decodes address and address modifier against the board window. It issues single-cycle read/write strobes to the register block, drives the data-bus direction and generates DTACK with active negation. It sits between the VME pins and the board register file/readback multiplexer and owns all bus-cycle timing.

## Interface
- BASE_ADDR, 16'h7C80: board window base; the window is BASE_ADDR[15:6] plus 32 word registers.
- DTACK_DELAY, 2: wait cycles from the register strobe to DTACK assertion; range 0..15.
- TIMEOUT, 255: maximum cycles DTACK is held waiting for strobe release; range 1..255.
- I_CLK_32M  in  1  system clock, 32 MHz.
- I_VME_SYSRESET  in  1  reset; asynchronous and active-high.
- I_VME_AS, I_VME_DS0, I_VME_DS1  in  1 each  VME strobes, active-low, asynchronous.
- I_VME_WR  in  1  VME WRITE*, low = write.
- I_VME_LWORD  in  1  VME LWORD*.
- I_VME_A  in  15  address bits [15:1].
- I_VME_AM  in  6  address modifier.
- I_VME_D  in  16  VME data bus, input side.
- I_REG_RDATA  in  16  combinational readback from the register block for O_REG_ADDR.
- O_REG_ADDR  out  5  word index A[5:1], held from DECODE to IDLE.
- O_REG_BE  out  2  byte enables {~DS1,~DS0}, captured in DECODE.
- O_REG_WR / O_REG_RD  out  1  one-cycle register strobes.
- O_WDATA  out  16  write data captured in DECODE.
- O_RDATA  out  16  read data captured in ACCESS.
- O_D_OE  out  1  drive O_RDATA onto VME_D.
- O_VME_DTACK_D  out  1  DTACK driver data; 0 = asserted.
- O_VME_DTACK_EN  out  1  DTACK driver enable.
- O_BUSY  out  1  high in every state except IDLE.
- O_TIMEOUT  out  1  one-cycle pulse on a release timeout.

## Operation
- AS, DS0, DS1 and WR each pass through a 2-flop synchronizer. Address, AM, LWORD and data are sampled unsynchronised, only while synchronized AS is low; VME guarantees they are stable then.
- State flow: IDLE, DECODE, ACCESS, WAIT, DTACK, RELEASE, WAIT_REL.
- IDLE → DECODE: synced AS low and at least one synced DS low.
- DECODE, match condition: AM ∈ {6'h29, 6'h2D}, A[15:6] == BASE_ADDR[15:6], and LWORD = 1.
  - On a match: capture O_REG_ADDR, O_REG_BE and O_WDATA, then go to ACCESS.
  - On no match: go to WAIT_REL; no DTACK, no strobes.
- ACCESS (1 cycle): pulse O_REG_WR on a write or O_REG_RD on a read. On a read, latch I_REG_RDATA into O_RDATA. Then go to WAIT.
- WAIT: count DTACK_DELAY cycles; go directly to DTACK when DTACK_DELAY = 0.
- DTACK: O_VME_DTACK_EN = 1, O_VME_DTACK_D = 0.
  - When both synced DS are high: go to RELEASE.
  - When the TIMEOUT counter expires: pulse O_TIMEOUT and go to WAIT_REL, with DTACK_EN = 0 and O_D_OE = 0.
- RELEASE (1 cycle): DTACK_D = 1 and DTACK_EN = 1 (active negation), then go to WAIT_REL.
- WAIT_REL: DTACK_EN = 0. Go to IDLE when synced AS is high.
- O_D_OE is high from the cycle after ACCESS through RELEASE, on reads only.
- Boundary conditions:
  - AS rising before DS releases is handled by the DTACK exit rule; DS is the only release condition.
  - Both DS high in DECODE (glitch) → WAIT_REL.
  - Byte accesses are acknowledged, with O_REG_BE reflecting the active lanes.
  - The timeout counter saturates and runs only in DTACK.

## Timing
- Reset (asynchronous, immediate), output values:
  - O_REG_WR = O_REG_RD = O_D_OE = O_VME_DTACK_EN = O_TIMEOUT = 0.
  - O_VME_DTACK_D = 1.
  - O_REG_ADDR, O_REG_BE, O_WDATA, O_RDATA = 0; synchronizers = 1 (idle).
  - FSM = WAIT_REL, so a cycle already in progress when reset releases is ignored until AS goes high.
- Latency from DS falling at the pin:
  - 2 cycles of sync.
  - DECODE at cycle 3, ACCESS at cycle 4.
  - DTACK asserted at cycle 5 + DTACK_DELAY; defaults give cycle 7, about 219 ns.
- DTACK release: DTACK_D goes high 3 cycles after the last DS rises at the pin; DTACK_EN drops one cycle later.
- Next cycle: minimum 1 cycle in IDLE between bus cycles.

## Structure
- Shared package vme_pkg:
  - AM constants AM_A16_NP = 6'h29 and AM_A16_SUP = 6'h2D.
  - State enum vme_state_t.
  - Board base constant EA4163_BASE = 16'h7C80.
- Sub-module vme_sync: parameterised-width 2-flop synchronizer with a reset value parameter, instantiated once with width 4.

## Test plan
- A16 read at 0x7CA4, AM 0x29, I_REG_RDATA = 16'hA800 → O_REG_ADDR = 5'h12, one O_REG_RD pulse, O_RDATA = 16'hA800 with O_D_OE high, DTACK asserted 7 cycles after DS.
- A16 write at 0x7C86 with D = 16'h1234 → one O_REG_WR pulse, O_WDATA = 16'h1234, O_REG_BE = 2'b11, O_D_OE never high.
- Address 0x7D00 or AM 0x39 → no strobes, DTACK_EN stays 0, FSM returns to IDLE after AS high.
- DS held low 300 cycles after DTACK → O_TIMEOUT pulses once at TIMEOUT; DTACK_EN = 0; no new cycle until AS high.
- Reset asserted in the DTACK state with AS low → outputs go to reset values immediately; after reset release, no strobe until AS goes high and a new cycle starts.
- Byte write with DS0 only, at 0x7C80 → O_REG_BE = 2'b01, DTACK then active negation for 1 cycle after DS0 high.
